itf_packet_rx: RTL and testbench

ITF_PACKET_RX -- requirements
Module: itf_packet_rx

---
 rtl/itf_packet_rx.sv | 136 +++++++++++++
 tb/tb_itf_packet_rx.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/itf_packet_rx.sv
// itf_packet_rx: assembles header+4-byte packets into a first-word-fall-through FIFO.
// Define ITF_RX_CHECKSUM_EN to require a trailing XOR checksum byte per packet.
module itf_packet_rx #(
    parameter int DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [1:0]  itf_packet_type,
    output logic [31:0] itf_data,
    output logic        itf_empty,
    input  logic        fifo_re,
    output logic        rx_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

`ifdef ITF_RX_CHECKSUM_EN
    typedef enum logic [1:0] {S_HDR, S_PAYLOAD, S_CHECK, S_COMMIT} state_t;
`else
    typedef enum logic [1:0] {S_HDR, S_PAYLOAD, S_COMMIT} state_t;
`endif

    state_t      state;
    logic [1:0]  cnt;
    logic [1:0]  ptype;
    logic [31:0] word;

    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [CW-1:0] count;
    logic [33:0]   mem [DEPTH];

    logic full;
    logic accept;
    logic push;
    logic pop;

    assign full      = (count == CW'(DEPTH));
    assign itf_empty = (count == '0);
    assign rx_ready  = (state != S_COMMIT);
    assign accept    = rx_valid && rx_ready;
    assign push      = (state == S_COMMIT) && !full;
    assign pop       = fifo_re && !itf_empty;

    assign itf_packet_type = itf_empty ? 2'b00 : mem[rptr][33:32];
    assign itf_data        = mem[rptr][31:0];

`ifdef ITF_RX_CHECKSUM_EN
    logic [7:0] csum;
    logic       rx_err_q;
    assign rx_err = rx_err_q;
`else
    assign rx_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_HDR;
            cnt   <= 2'd0;
            ptype <= 2'b00;
            word  <= 32'd0;
`ifdef ITF_RX_CHECKSUM_EN
            csum     <= 8'd0;
            rx_err_q <= 1'b0;
`endif
        end else begin
`ifdef ITF_RX_CHECKSUM_EN
            rx_err_q <= 1'b0;
`endif
            case (state)
                S_HDR: begin
                    // Type 00 headers are fillers and never open a packet.
                    if (accept && rx_data[7:6] != 2'b00) begin
                        ptype <= rx_data[7:6];
                        cnt   <= 2'd0;
                        state <= S_PAYLOAD;
`ifdef ITF_RX_CHECKSUM_EN
                        csum  <= rx_data;
`endif
                    end
                end
                S_PAYLOAD: begin
                    if (accept) begin
                        word <= {word[23:0], rx_data};
                        cnt  <= cnt + 2'd1;
`ifdef ITF_RX_CHECKSUM_EN
                        csum <= csum ^ rx_data;
                        if (cnt == 2'd3) state <= S_CHECK;
`else
                        if (cnt == 2'd3) state <= S_COMMIT;
`endif
                    end
                end
`ifdef ITF_RX_CHECKSUM_EN
                S_CHECK: begin
                    if (accept) begin
                        if (rx_data == csum) begin
                            state <= S_COMMIT;
                        end else begin
                            rx_err_q <= 1'b1;
                            state    <= S_HDR;
                        end
                    end
                end
`endif
                S_COMMIT: begin
                    if (!full) state <= S_HDR;
                end
                default: state <= S_HDR;
            endcase
        end
    end

    // Fullness is judged before any same-cycle pop, so a full FIFO
    // always defers the push by one cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop)  rptr <= rptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && push) mem[wptr] <= {ptype, word};
    end

endmodule

// File: tb/tb_itf_packet_rx.sv
// tb_itf_packet_rx: directed and randomized checks of itf_packet_rx
// against a packet-level queue model.
module tb_itf_packet_rx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [1:0]  itf_packet_type;
    logic [31:0] itf_data;
    logic        itf_empty;
    logic        fifo_re = 1'b0;
    logic        rx_err;

    int checks = 0;
    int failures = 0;

    logic [33:0] exp_q[$];

    always #5 clk = ~clk;

    itf_packet_rx #(.DEPTH(16)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_ready       (rx_ready),
        .itf_packet_type(itf_packet_type),
        .itf_data       (itf_data),
        .itf_empty      (itf_empty),
        .fifo_re        (fifo_re),
        .rx_err         (rx_err)
    );

    function automatic logic [7:0] csum_of(input logic [7:0] h, input logic [31:0] w);
        return h ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
    endfunction

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!rx_ready) begin
            checks++; failures++;
            $display("FAIL send_byte_timeout rx_ready=%b required=1", rx_ready);
        end
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_pkt(input logic [7:0] hdr, input logic [31:0] w);
        send_byte(hdr);
        for (int i = 0; i < 4; i++) send_byte(w[31-8*i -: 8]);
`ifdef ITF_RX_CHECKSUM_EN
        send_byte(csum_of(hdr, w));
`endif
    endtask

    task automatic pop_one();
        fifo_re = 1'b1;
        @(posedge clk); #1;
        fifo_re = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; fifo_re = 1'b0; rx_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic drain(input int expn, input string name);
        int got;
        int n;
        got = 0;
        n = 0;
        while (!itf_empty && n < 200) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL %s_extra got=%h required=none", name, {itf_packet_type, itf_data});
            end else begin
                if ({itf_packet_type, itf_data} !== exp_q[0]) begin
                    failures++;
                    $display("FAIL %s_head got=%h required=%h", name,
                             {itf_packet_type, itf_data}, exp_q[0]);
                end
                void'(exp_q.pop_front());
            end
            pop_one();
            got++;
            n++;
        end
        checks++;
        if (got != expn || exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_count got=%0d required=%0d left=%0d", name, got, expn, exp_q.size());
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (rx_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b required=1", rx_ready); end
        checks++;
        if (itf_empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b required=1", itf_empty); end
        checks++;
        if (itf_packet_type !== 2'b00) begin failures++; $display("FAIL reset_type got=%b required=00", itf_packet_type); end
        checks++;
        if (rx_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b required=0", rx_err); end
    endtask

    task automatic test_basic();
        send_pkt(8'h40, 32'hDEADBEEF);
        checks++;
        if (rx_ready !== 1'b0) begin failures++; $display("FAIL basic_commit_ready got=%b required=0", rx_ready); end
        checks++;
        if (itf_empty !== 1'b1) begin failures++; $display("FAIL basic_pre_empty got=%b required=1", itf_empty); end
        @(posedge clk); #1;
        checks++;
        if (itf_empty !== 1'b0) begin failures++; $display("FAIL basic_empty got=%b required=0", itf_empty); end
        checks++;
        if (itf_packet_type !== 2'b01) begin failures++; $display("FAIL basic_type got=%b required=01", itf_packet_type); end
        checks++;
        if (itf_data !== 32'hDEADBEEF) begin failures++; $display("FAIL basic_data got=%h required=deadbeef", itf_data); end
        pop_one();
        checks++;
        if (itf_empty !== 1'b1 || itf_packet_type !== 2'b00) begin
            failures++;
            $display("FAIL basic_pop empty=%b type=%b required=1/00", itf_empty, itf_packet_type);
        end
    endtask

    task automatic test_type0();
        send_byte(8'h00);
        checks++;
        if (itf_empty !== 1'b1) begin failures++; $display("FAIL type0_empty got=%b required=1", itf_empty); end
        send_pkt(8'h80, 32'h00000001);
        @(posedge clk); #1;
        checks++;
        if (itf_packet_type !== 2'b10 || itf_data !== 32'h1) begin
            failures++;
            $display("FAIL type0_entry got=%b/%h required=10/00000001", itf_packet_type, itf_data);
        end
        pop_one();
        checks++;
        if (itf_empty !== 1'b1) begin failures++; $display("FAIL type0_single got=%b required=1", itf_empty); end
    endtask

    task automatic test_empty_read();
        fifo_re = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        fifo_re = 1'b0;
        checks++;
        if (itf_empty !== 1'b1 || itf_packet_type !== 2'b00) begin
            failures++;
            $display("FAIL empty_read empty=%b type=%b required=1/00", itf_empty, itf_packet_type);
        end
        exp_q.delete();
        exp_q.push_back({2'b11, 32'h12345678});
        send_pkt(8'hC5, 32'h12345678);
        @(posedge clk); #1;
        drain(1, "empty_read");
    endtask

    task automatic test_full();
        logic [1:0]  t;
        logic [31:0] w;
        exp_q.delete();
        for (int k = 0; k < 17; k++) begin
            t = 2'($urandom_range(1, 3));
            w = $urandom;
            exp_q.push_back({t, w});
            send_pkt({t, 6'($urandom)}, w);
        end
        repeat (3) begin @(posedge clk); #1; end
        checks++;
        if (rx_ready !== 1'b0) begin failures++; $display("FAIL full_ready got=%b required=0", rx_ready); end
        checks++;
        if ({itf_packet_type, itf_data} !== exp_q[0]) begin
            failures++;
            $display("FAIL full_head got=%h required=%h", {itf_packet_type, itf_data}, exp_q[0]);
        end
        pop_one();
        void'(exp_q.pop_front());
        checks++;
        if (rx_ready !== 1'b0) begin failures++; $display("FAIL full_same_cycle_push got=%b required=0", rx_ready); end
        @(posedge clk); #1;
        checks++;
        if (rx_ready !== 1'b1) begin failures++; $display("FAIL full_late_push got=%b required=1", rx_ready); end
        drain(16, "full");
    endtask

    task automatic test_reset_mid();
        send_pkt(8'h40, 32'hCAFEF00D);
        @(posedge clk); #1;
        send_byte(8'h80);
        send_byte(8'h11);
        send_byte(8'h22);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checks++;
        if (itf_empty !== 1'b1 || itf_packet_type !== 2'b00 || rx_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid empty=%b type=%b ready=%b required=1/00/1",
                     itf_empty, itf_packet_type, rx_ready);
        end
        exp_q.delete();
        exp_q.push_back({2'b11, 32'hA5A55A5A});
        send_pkt(8'hC0, 32'hA5A55A5A);
        @(posedge clk); #1;
        drain(1, "reset_mid");
    endtask

    task automatic test_random();
        logic [7:0]  stream[$];
        logic [1:0]  t;
        logic [31:0] w;
        logic [7:0]  h;
        logic        acc;
        int          idx;
        int          cyc;
        exp_q.delete();
        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 4) == 0) begin
                stream.push_back({2'b00, 6'($urandom)});
            end else begin
                t = 2'($urandom_range(1, 3));
                w = $urandom;
                h = {t, 6'($urandom)};
                exp_q.push_back({t, w});
                stream.push_back(h);
                for (int i = 0; i < 4; i++) stream.push_back(w[31-8*i -: 8]);
`ifdef ITF_RX_CHECKSUM_EN
                stream.push_back(csum_of(h, w));
`endif
            end
        end
        idx = 0;
        cyc = 0;
        while ((idx < stream.size() || exp_q.size() > 0) && cyc < 5000) begin
            rx_valid = (idx < stream.size()) && ($urandom_range(0, 3) != 0);
            rx_data  = (idx < stream.size()) ? stream[idx] : 8'h00;
            fifo_re  = ($urandom_range(0, 2) == 0);
            acc = rx_valid && rx_ready;
            if (fifo_re && !itf_empty) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL random_extra got=%h required=none", {itf_packet_type, itf_data});
                end else begin
                    if ({itf_packet_type, itf_data} !== exp_q[0]) begin
                        failures++;
                        $display("FAIL random_head got=%h required=%h",
                                 {itf_packet_type, itf_data}, exp_q[0]);
                    end
                    void'(exp_q.pop_front());
                end
            end else if (itf_empty) begin
                checks++;
                if (itf_packet_type !== 2'b00) begin
                    failures++;
                    $display("FAIL random_empty_type got=%b required=00", itf_packet_type);
                end
            end
`ifndef ITF_RX_CHECKSUM_EN
            if (rx_err !== 1'b0) begin
                checks++; failures++;
                $display("FAIL random_err got=%b required=0", rx_err);
            end
`endif
            @(posedge clk); #1;
            if (acc) idx++;
            cyc++;
        end
        rx_valid = 1'b0;
        fifo_re  = 1'b0;
        checks++;
        if (idx != stream.size() || exp_q.size() != 0 || itf_empty !== 1'b1) begin
            failures++;
            $display("FAIL random_done sent=%0d of %0d left=%0d empty=%b required=all/0/1",
                     idx, stream.size(), exp_q.size(), itf_empty);
        end
    endtask

`ifdef ITF_RX_CHECKSUM_EN
    task automatic test_checksum();
        logic [7:0] good[6];
        good = '{8'hC0, 8'h01, 8'h02, 8'h03, 8'h04, 8'hC4};
        for (int i = 0; i < 6; i++) send_byte(good[i]);
        @(posedge clk); #1;
        checks++;
        if (itf_empty !== 1'b0 || itf_packet_type !== 2'b11 || itf_data !== 32'h01020304) begin
            failures++;
            $display("FAIL csum_good empty=%b type=%b data=%h required=0/11/01020304",
                     itf_empty, itf_packet_type, itf_data);
        end
        pop_one();
        for (int i = 0; i < 5; i++) send_byte(good[i]);
        send_byte(8'h00);
        checks++;
        if (rx_err !== 1'b1) begin failures++; $display("FAIL csum_err_pulse got=%b required=1", rx_err); end
        @(posedge clk); #1;
        checks++;
        if (rx_err !== 1'b0) begin failures++; $display("FAIL csum_err_len got=%b required=0", rx_err); end
        checks++;
        if (itf_empty !== 1'b1) begin failures++; $display("FAIL csum_bad_empty got=%b required=1", itf_empty); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_type0();
        test_empty_read();
        test_full();
        test_reset_mid();
`ifdef ITF_RX_CHECKSUM_EN
        test_checksum();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
